// File: rtl/multiplicador_sequencial_if.sv
// Request/result bundle between the sequential multiplier and its client.
// master drives operands and start; slave (the multiplier) drives status and result.
interface multiplicador_sequencial_if #(parameter int WIDTH = 8);
  logic                 iniciar;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2:0]           destino;
  logic                 pronto;
  logic                 ocupado;
  logic [2*WIDTH-1:0]   produto;
  logic [2:0]           op;
  logic                 valido;
  logic                 erro;

  modport master (
    output iniciar, op_a, op_b, destino,
    input  pronto, ocupado, produto, op, valido, erro
  );

  modport slave (
    input  iniciar, op_a, op_b, destino,
    output pronto, ocupado, produto, op, valido, erro
  );
endinterface

// File: rtl/multiplicador_sequencial.sv
// Shift-and-add multiplier feeding the six-way result demux; op idles at 3'b111.
// Optional signed operands when MULT_SIGNED_EN is defined (magnitude core + final negate).
module multiplicador_sequencial #(
  parameter int WIDTH = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  multiplicador_sequencial_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {OCIOSO, CALCULA, ESCREVE} estado_t;

  estado_t              state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   produto_q, produto_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2:0]           dest_q, dest_d;
  logic [2:0]           op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valido_q, valido_d;
  logic                 erro_q, erro_d;
  logic                 aceita, rejeita;
  logic                 pronto, ocupado;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   resultado;

  assign aceita  = (state_q == OCIOSO) && bus.iniciar && (bus.destino <= 3'd5);
  assign rejeita = (state_q == OCIOSO) && bus.iniciar && (bus.destino >  3'd5);

`ifdef MULT_SIGNED_EN
  logic sign_q;
  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude
  assign mag_a     = bus.op_a[WIDTH-1] ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
  assign mag_b     = bus.op_b[WIDTH-1] ? (~bus.op_b + WIDTH'(1)) : bus.op_b;
  assign resultado = sign_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    sign_q <= 1'b0;
    else if (aceita) sign_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
  end
`else
  assign mag_a     = bus.op_a;
  assign mag_b     = bus.op_b;
  assign resultado = acc_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= OCIOSO;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (aceita) state_d = CALCULA;
      CALCULA: if (cnt_q == CW'(WIDTH - 1)) state_d = ESCREVE;
      ESCREVE: state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    pronto  = (state_q == OCIOSO);
    ocupado = (state_q == CALCULA) || (state_q == ESCREVE);
  end

  // Result registers load on the edge leaving ESCREVE, so valido/op form one clean registered pulse
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    produto_d = produto_q;
    op_d      = 3'b111;
    valido_d  = 1'b0;
    erro_d    = rejeita;
    case (state_q)
      OCIOSO: if (aceita) begin
        mcand_d  = {{WIDTH{1'b0}}, mag_a};
        mplier_d = mag_b;
        acc_d    = '0;
        cnt_d    = '0;
        dest_d   = bus.destino;
      end
      CALCULA: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      ESCREVE: begin
        produto_d = resultado;
        op_d      = dest_q;
        valido_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      produto_q <= '0;
      op_q      <= 3'b111;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      produto_q <= produto_d;
      op_q      <= op_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.pronto  = pronto;
  assign bus.ocupado = ocupado;
  assign bus.produto = produto_q;
  assign bus.op      = op_q;
  assign bus.valido  = valido_q;
  assign bus.erro    = erro_q;
endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Self-checking bench: directed vector table, hand-built corner sequences and
// randomized operands compared against an arithmetic reference product.
module tb_multiplicador_sequencial;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset_n;
  int checks = 0;
  int failures = 0;

  multiplicador_sequencial_if #(.WIDTH(W)) bus ();
  multiplicador_sequencial #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     d;
    logic [2*W-1:0] prod;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y;
`ifdef MULT_SIGNED_EN
    x = a[W-1] ? int'(a) - (1 << W) : int'(a);
    y = b[W-1] ? int'(b) - (1 << W) : int'(b);
`else
    x = int'(a);
    y = int'(b);
`endif
    return (2*W)'(x * y);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pronto"},  bus.pronto,  1);
    chk({tag, "_ocupado"}, bus.ocupado, 0);
    chk({tag, "_produto"}, bus.produto, 0);
    chk({tag, "_op"},      bus.op,      3'b111);
    chk({tag, "_valido"},  bus.valido,  0);
    chk({tag, "_erro"},    bus.erro,    0);
  endtask

  // Start one multiplication and follow it to its valido pulse; optionally fire a
  // second iniciar mid-computation, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] d,
                        input logic [2*W-1:0] exp, input bit inject);
    bit seen = 0;
    @(negedge clock);
    bus.iniciar = 1'b1; bus.op_a = a; bus.op_b = b; bus.destino = d;
    @(negedge clock);
    bus.iniciar = 1'b0; bus.op_a = W'($urandom); bus.op_b = W'($urandom);
    bus.destino = 3'($urandom);
    for (int k = 1; k <= W + 4 && !seen; k++) begin
      if (k > 1) @(negedge clock);
      if (bus.valido) begin
        seen = 1;
        chk("latency", k, W + 2);
        chk("produto", bus.produto, exp);
        chk("op_dest", bus.op, d);
        chk("erro_run", bus.erro, 0);
      end else begin
        chk("op_idle", bus.op, 3'b111);
        if (k < W + 2) chk("ocupado", bus.ocupado, 1);
      end
      if (inject && k == 3) begin
        bus.iniciar = 1'b1; bus.op_a = 2; bus.op_b = 2; bus.destino = 3'd0;
      end
      if (inject && k == 4) bus.iniciar = 1'b0;
    end
    if (!seen) chk("valido_timeout", 0, 1);
    @(negedge clock);
    chk("valido_drop", bus.valido, 0);
    chk("op_after",    bus.op,     3'b111);
    chk("pronto_after", bus.pronto, 1);
  endtask

  task automatic run_erro(input logic [2:0] d);
    logic [2*W-1:0] prev;
    @(negedge clock);
    prev = bus.produto;
    bus.iniciar = 1'b1; bus.op_a = 9; bus.op_b = 9; bus.destino = d;
    @(negedge clock);
    bus.iniciar = 1'b0;
    chk("erro_pulse",  bus.erro,    1);
    chk("erro_pronto", bus.pronto,  1);
    chk("erro_valido", bus.valido,  0);
    chk("erro_prod",   bus.produto, prev);
    chk("erro_op",     bus.op,      3'b111);
    @(negedge clock);
    chk("erro_drop",   bus.erro,    0);
    chk("erro_pronto2", bus.pronto, 1);
    chk("erro_valido2", bus.valido, 0);
  endtask

  vec_t vecs[$];

  initial begin
`ifdef MULT_SIGNED_EN
    vecs.push_back('{8'hFD, 8'd5,  3'd2, 16'hFFF1});
    vecs.push_back('{8'h80, 8'h80, 3'd5, 16'h4000});
    vecs.push_back('{8'hFF, 8'd1,  3'd0, 16'hFFFF});
    vecs.push_back('{8'd13, 8'd11, 3'd2, 16'h008F});
    vecs.push_back('{8'hFF, 8'hFF, 3'd3, 16'h0001});
`else
    vecs.push_back('{8'd13,  8'd11,  3'd2, 16'h008F});
    vecs.push_back('{8'd255, 8'd255, 3'd5, 16'hFE01});
    vecs.push_back('{8'd0,   8'd200, 3'd0, 16'h0000});
    vecs.push_back('{8'd100, 8'd100, 3'd4, 16'h2710});
    vecs.push_back('{8'd128, 8'd2,   3'd3, 16'h0100});
    vecs.push_back('{8'd1,   8'd255, 3'd1, 16'h00FF});
`endif
    reset_n = 1'b0;
    bus.iniciar = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.destino = '0;
    repeat (2) @(negedge clock);
    chk_reset_vals("rst");
    reset_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].prod, 0);

    run_erro(3'd6);
    run_erro(3'd7);

    // Second start during computation is dropped; a fresh one afterwards works
    run_op(8'd13, 8'd11, 3'd2, 16'h008F, 1);
    run_op(8'd2, 8'd2, 3'd4, 16'h0004, 0);

    // Reset in the middle of a computation
    @(negedge clock);
    bus.iniciar = 1'b1; bus.op_a = 200; bus.op_b = 3; bus.destino = 3'd3;
    @(negedge clock);
    bus.iniciar = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clock);
      chk("no_valido_post_rst", bus.valido, 0);
    end
    run_op(8'd7, 8'd6, 3'd1, 16'h002A, 0);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      logic [2:0] d;
      a = W'($urandom);
      b = W'($urandom);
      d = 3'($urandom_range(0, 5));
      run_op(a, b, d, ref_mul(a, b), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
